mii_tx_frame_builder: RTL and testbench

- Upstream stage of the MII transmit encoder, in the same i_clk domain.
- Accepts per-frame payload bytes on a valid/ready stream together with destination MAC and EtherType, and queues complete frames.
- Emits each frame to the encoder's tx_en/tx_data/tx_ready interface as one gapless byte burst: dst MAC, src MAC, EtherType, payload.
- The encoder handles padding and FCS; this block never emits preamble, SFD, pad or FCS.

---
 rtl/mii_tx_frame_builder_if.sv | 20 ++
 rtl/mii_tx_frame_builder.sv | 174 +++++++++++++++++
 tb/tb_mii_tx_frame_builder.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mii_tx_frame_builder_if.sv
// Ingress payload stream of the MII frame builder: bytes plus the
// per-frame header fields sampled on the last beat.
interface mii_tx_frame_builder_if;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic        s_ready;
    logic [47:0] i_dst_mac;
    logic [15:0] i_ethertype;

    modport master (
        output s_valid, s_data, s_last, i_dst_mac, i_ethertype,
        input  s_ready
    );

    modport slave (
        input  s_valid, s_data, s_last, i_dst_mac, i_ethertype,
        output s_ready
    );
endinterface

// File: rtl/mii_tx_frame_builder.sv
// Queues complete frames (payload FIFO + header FIFO) and replays each
// one to the MII encoder as a single gapless dst/src/type/payload burst.
module mii_tx_frame_builder #(
    parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
    parameter int          MAX_PAYLOAD = 1500,
    parameter int          PAY_DEPTH   = 2048,
    parameter int          HDR_DEPTH   = 4,
    parameter int          IFG_CYCLES  = 2
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    mii_tx_frame_builder_if.slave  stream,
    output logic                   tx_en,
    output logic [7:0]             tx_data,
    input  logic                   tx_ready,
    output logic                   o_busy,
    output logic [15:0]            o_frames_sent,
    output logic                   o_truncated
);
    localparam int PAW = $clog2(PAY_DEPTH);
    localparam int PCW = $clog2(PAY_DEPTH + 1);
    localparam int HAW = $clog2(HDR_DEPTH);
    localparam int HCW = $clog2(HDR_DEPTH + 1);
    localparam logic [10:0] MAXP  = 11'(MAX_PAYLOAD);
    localparam logic [10:0] LASTP = 11'(MAX_PAYLOAD - 1);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, GAP} state_t;

    state_t state;

    logic [8:0]     pay_mem [PAY_DEPTH];
    logic [PAW-1:0] pay_wp, pay_rp;
    logic [PCW-1:0] pay_cnt;
    logic [8:0]     pay_head, pay_wdata;
    logic           pay_push, pay_pop;

    logic [63:0]    hdr_mem [HDR_DEPTH];
    logic [HAW-1:0] hdr_wp, hdr_rp;
    logic [HCW-1:0] hdr_cnt;
    logic [63:0]    hdr_head;
    logic           hdr_push, hdr_pop;

    logic [10:0]    wc;
    logic           ready, accept;
    logic [3:0]     idx;
    logic [103:0]   shreg;
    logic           cur_last;
    logic [7:0]     gap_cnt;

    function automatic logic [PAW-1:0] pay_inc(input logic [PAW-1:0] p);
        return (p == PAW'(PAY_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ready = (pay_cnt != PCW'(PAY_DEPTH)) &&
                   (hdr_cnt != HCW'(HDR_DEPTH));
    assign stream.s_ready = ready;
    assign accept = stream.s_valid && ready;

    // Bytes past the truncation point are swallowed; the last stored
    // byte already carries the end marker.
    assign pay_push  = accept && (wc < MAXP);
    assign pay_wdata = {stream.s_last || (wc == LASTP), stream.s_data};
    assign hdr_push  = accept && stream.s_last;

    assign o_truncated = hdr_push && (wc >= MAXP);

    assign pay_head = pay_mem[pay_rp];
    assign hdr_head = hdr_mem[hdr_rp];

    assign hdr_pop = (state == IDLE) && (hdr_cnt != '0) && tx_ready;
    assign pay_pop = ((state == HEADER) && (idx == 4'd13)) ||
                     ((state == PAYLOAD) && !cur_last);

    assign o_busy = (state != IDLE);

    always_ff @(posedge i_clk) begin
        if (pay_push)
            pay_mem[pay_wp] <= pay_wdata;
        if (hdr_push)
            hdr_mem[hdr_wp] <= {stream.i_dst_mac, stream.i_ethertype};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pay_wp  <= '0;
            pay_rp  <= '0;
            pay_cnt <= '0;
            hdr_wp  <= '0;
            hdr_rp  <= '0;
            hdr_cnt <= '0;
            wc      <= '0;
        end else begin
            if (pay_push)
                pay_wp <= pay_inc(pay_wp);
            if (pay_pop)
                pay_rp <= pay_inc(pay_rp);
            pay_cnt <= pay_cnt + PCW'(pay_push) - PCW'(pay_pop);
            if (hdr_push)
                hdr_wp <= hdr_wp + 1'b1;
            if (hdr_pop)
                hdr_rp <= hdr_rp + 1'b1;
            hdr_cnt <= hdr_cnt + HCW'(hdr_push) - HCW'(hdr_pop);
            if (accept) begin
                if (stream.s_last)
                    wc <= '0;
                else if (wc < MAXP)
                    wc <= wc + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= IDLE;
            tx_en         <= 1'b0;
            tx_data       <= '0;
            idx           <= '0;
            shreg         <= '0;
            cur_last      <= 1'b0;
            gap_cnt       <= '0;
            o_frames_sent <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (hdr_pop) begin
                        state   <= HEADER;
                        tx_en   <= 1'b1;
                        tx_data <= hdr_head[63:56];
                        shreg   <= {hdr_head[55:16], SRC_MAC,
                                    hdr_head[15:0]};
                        idx     <= '0;
                    end
                end
                HEADER: begin
                    // Payload byte 0 is already at the FIFO head, so the
                    // header-to-payload hand-off has no bubble.
                    if (idx == 4'd13) begin
                        tx_data  <= pay_head[7:0];
                        cur_last <= pay_head[8];
                        state    <= PAYLOAD;
                    end else begin
                        tx_data <= shreg[103:96];
                        shreg   <= shreg << 8;
                        idx     <= idx + 1'b1;
                    end
                end
                PAYLOAD: begin
                    if (cur_last) begin
                        tx_en         <= 1'b0;
                        tx_data       <= '0;
                        o_frames_sent <= o_frames_sent + 1'b1;
                        if (IFG_CYCLES > 1) begin
                            state   <= GAP;
                            gap_cnt <= 8'(IFG_CYCLES - 2);
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        tx_data  <= pay_head[7:0];
                        cur_last <= pay_head[8];
                    end
                end
                GAP: begin
                    // The IDLE cycle is the final low cycle of the gap.
                    if (gap_cnt == '0)
                        state <= IDLE;
                    else
                        gap_cnt <= gap_cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mii_tx_frame_builder.sv
// Scoreboard bench: stimulus pushes expected burst bytes, a negedge
// monitor pops and compares every byte the DUT drives on tx_en.
module tb_mii_tx_frame_builder;
    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b1;
    logic        o_busy;
    logic [15:0] o_frames_sent;
    logic        o_truncated;

    always #5 i_clk = ~i_clk;

    mii_tx_frame_builder_if sif ();

    mii_tx_frame_builder dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .stream        (sif),
        .tx_en         (tx_en),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .o_busy        (o_busy),
        .o_frames_sent (o_frames_sent),
        .o_truncated   (o_truncated)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];
    bit abort_pending = 0;
    bit prev_en = 0;
    bit seen_burst = 0;
    int trunc_cnt = 0;
    int low_run = 0;
    int last_gap = -1;
    int cur_len = 0;
    int last_len = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge i_clk) begin
        bit ok;
        if (o_truncated === 1'b1)
            trunc_cnt++;
        if (tx_en === 1'b1) begin
            if (!prev_en) begin
                if (seen_burst)
                    last_gap = low_run;
                cur_len = 0;
            end
            cur_len++;
            ok = (exp_q.size() > 0) && (exp_q[0] >= 0);
            check("byte_avail", ok, 1);
            if (ok)
                check("tx_byte", tx_data, exp_q.pop_front());
            prev_en = 1;
        end else begin
            if (prev_en) begin
                low_run = 0;
                if (abort_pending) begin
                    abort_pending = 0;
                    seen_burst = 0;
                end else begin
                    ok = (exp_q.size() > 0) && (exp_q[0] == -1);
                    check("burst_end", ok, 1);
                    if (ok)
                        void'(exp_q.pop_front());
                    seen_burst = 1;
                    last_len = cur_len;
                end
                cur_len = 0;
            end
            low_run++;
            prev_en = 0;
        end
    end

    task automatic send_frame(input logic [47:0] dst, input logic [15:0] et,
                              input int len, input int base, input int step);
        logic [47:0] src;
        int n;
        int t;
        src = 48'h02_00_00_00_00_01;
        n = (len < 1500) ? len : 1500;
        for (int i = 0; i < 6; i++)
            exp_q.push_back(int'(dst[47-8*i -: 8]));
        for (int i = 0; i < 6; i++)
            exp_q.push_back(int'(src[47-8*i -: 8]));
        exp_q.push_back(int'(et[15:8]));
        exp_q.push_back(int'(et[7:0]));
        for (int k = 0; k < n; k++)
            exp_q.push_back((base + k * step) & 255);
        exp_q.push_back(-1);
        for (int k = 0; k < len; k++) begin
            sif.s_valid     = 1'b1;
            sif.s_data      = 8'((base + k * step) & 255);
            sif.s_last      = (k == len - 1);
            sif.i_dst_mac   = dst;
            sif.i_ethertype = et;
            t = 0;
            forever begin
                @(negedge i_clk);
                if (sif.s_ready === 1'b1)
                    break;
                t++;
                if (t > 3000) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL s_ready_wait: got 0 want 1");
                    break;
                end
            end
            @(posedge i_clk);
            #1;
        end
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 5000; t++) begin
            @(negedge i_clk);
            if (exp_q.size() == 0 && tx_en === 1'b0 && o_busy === 1'b0)
                break;
        end
        check("drain_left", exp_q.size(), 0);
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int hi;
        int t0;
        sif.s_valid     = 1'b0;
        sif.s_data      = '0;
        sif.s_last      = 1'b0;
        sif.i_dst_mac   = '0;
        sif.i_ethertype = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_tx_en", tx_en, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_busy", o_busy, 0);
        check("rst_frames", o_frames_sent, 0);
        check("rst_trunc", o_truncated, 0);
        check("rst_s_ready", sif.s_ready, 1);
        @(posedge i_clk);
        #1 i_reset = 1'b0;

        // single frame
        send_frame(48'hFFFF_FFFF_FFFF, 16'h0800, 3, 'h11, 'h11);
        wait_drain();
        check("t1_len", last_len, 17);
        check("t1_frames", o_frames_sent, 1);
        check("t1_trunc", trunc_cnt, 0);

        // back-to-back, both queued before release
        tx_ready = 1'b0;
        send_frame(48'hA1A2_A3A4_A5A6, 16'h86DD, 50, 0, 1);
        send_frame(48'h0102_0304_0506, 16'h0806, 50, 'h80, 3);
        tx_ready = 1'b1;
        wait_drain();
        check("t2_gap", last_gap, 2);
        check("t2_len", last_len, 64);
        check("t2_frames", o_frames_sent, 3);

        // tx_ready held low
        tx_ready = 1'b0;
        send_frame(48'h0011_2233_4455, 16'h0004, 4, 'hC0, 1);
        hi = 0;
        repeat (100) begin
            @(negedge i_clk);
            if (tx_en !== 1'b0)
                hi++;
        end
        check("t3_hold_low", hi, 0);
        @(posedge i_clk);
        #1 tx_ready = 1'b1;
        @(negedge i_clk);
        check("t3_start_n", tx_en, 0);
        @(negedge i_clk);
        check("t3_start_n1", tx_en, 1);
        repeat (14) @(negedge i_clk);
        check("t3_pay0_n15", tx_data, 'hC0);
        @(posedge i_clk);
        #1;
        wait_drain();
        check("t3_frames", o_frames_sent, 4);

        // truncation, then an intact frame
        t0 = trunc_cnt;
        send_frame(48'h0A0B_0C0D_0E0F, 16'h0800, 1502, 7, 1);
        wait_drain();
        check("t4_trunc_pulses", trunc_cnt - t0, 1);
        check("t4_trunc_len", last_len, 1514);
        send_frame(48'h0A0B_0C0D_0E0F, 16'h0801, 5, 'h30, 1);
        wait_drain();
        check("t4_next_len", last_len, 19);
        check("t4_trunc_after", trunc_cnt - t0, 1);
        check("t4_frames", o_frames_sent, 6);

        // header FIFO backpressure
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send_frame(48'h5000_0000_0000 + 48'(i), 16'h0001, 1, 'hE0 + i, 1);
        @(negedge i_clk);
        check("t5_ready_low", sif.s_ready, 0);
        @(posedge i_clk);
        #1 tx_ready = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge i_clk);
            if (sif.s_ready === 1'b1)
                break;
        end
        check("t5_ready_back", sif.s_ready, 1);
        @(posedge i_clk);
        #1;
        send_frame(48'h5000_0000_0004, 16'h0001, 1, 'hE4, 1);
        wait_drain();
        check("t5_len", last_len, 15);
        check("t5_frames", o_frames_sent, 11);

        // reset in the middle of payload byte 10
        tx_ready = 1'b0;
        send_frame(48'h1122_3344_5566, 16'h88B5, 20, 'h40, 1);
        @(posedge i_clk);
        #1 tx_ready = 1'b1;
        hi = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge i_clk);
            if (tx_en === 1'b1)
                hi++;
            if (hi == 25)
                break;
        end
        check("t6_byte10", tx_data, 'h4A);
        #1;
        i_reset = 1'b1;
        exp_q.delete();
        abort_pending = 1;
        @(negedge i_clk);
        check("t6_tx_en", tx_en, 0);
        check("t6_frames", o_frames_sent, 0);
        check("t6_busy", o_busy, 0);
        check("t6_s_ready", sif.s_ready, 1);
        @(posedge i_clk);
        #1 i_reset = 1'b0;
        hi = 0;
        repeat (30) begin
            @(negedge i_clk);
            if (tx_en !== 1'b0)
                hi++;
        end
        check("t6_fifo_empty", hi, 0);
        @(posedge i_clk);
        #1;
        send_frame(48'hFEDC_BA98_7654, 16'h0800, 1, 'h5A, 1);
        wait_drain();
        check("t6_len", last_len, 15);
        check("t6_frames_after", o_frames_sent, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
